// File: rtl/rm_monitor_pkg.sv
// ============================================================================
// Module      : rm_monitor_pkg
// Description : Shared types and helpers for the runtime-monitor report path.
//               Defines the buffered report record and the FIFO level width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rm_monitor_pkg;

    localparam int RM_NUM_REPORTS = 4;
    localparam int RM_TS_WIDTH    = 32;

    // One buffered report: when it happened and which report STEs fired
    typedef struct packed {
        logic [RM_TS_WIDTH-1:0]    ts;
        logic [RM_NUM_REPORTS-1:0] bitmap;
    } rm_report_rec_t;

    // Level counter must represent 0..depth inclusive
    function automatic int rm_level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rm_report_fifo.sv
// ============================================================================
// Module      : rm_report_fifo
// Description : Synchronous FIFO of rm_report_rec_t records. A push while full
//               is accepted only when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rm_report_fifo
    import rm_monitor_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push_i,
    input  rm_report_rec_t              data_i,
    input  logic                        pop_i,
    output rm_report_rec_t              data_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [rm_level_w(DEPTH)-1:0] level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = rm_level_w(DEPTH);

    rm_report_rec_t   mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;
    logic             w_pop;
    logic             w_push;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign w_pop   = pop_i && !empty_o;
    assign w_push  = push_i && (!full_o || w_pop);

    // Head record is masked to zero while empty so outputs read 0 after reset
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Next pointer and level values from the accepted push/pop pair
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (w_push && !w_pop)      level_d = level_q + LVL_W'(1);
        else if (w_pop && !w_push) level_d = level_q - LVL_W'(1);
    end

    // Pointer and level registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents need no reset since the level gates visibility
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

`default_nettype wire

// File: rtl/rm_report_collector.sv
// ============================================================================
// Module      : rm_report_collector
// Description : Samples automata report lines on run cycles, timestamps
//               non-empty vectors and streams {ts, bitmap} records out over
//               valid/ready. Counts records lost to a full buffer.
//               Optional: RM_REPORT_DEDUP_EN records only bitmap changes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rm_report_collector
    import rm_monitor_pkg::*;
#(
    // NUM_REPORTS and TS_WIDTH must match the package record layout
    parameter int NUM_REPORTS = RM_NUM_REPORTS,
    parameter int TS_WIDTH    = RM_TS_WIDTH,
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              run,
    input  logic [NUM_REPORTS-1:0]            report_i,
    output logic                              rec_valid_o,
    input  logic                              rec_ready_i,
    output logic [TS_WIDTH-1:0]               rec_ts_o,
    output logic [NUM_REPORTS-1:0]            rec_bitmap_o,
    output logic [rm_level_w(FIFO_DEPTH)-1:0] fifo_level_o,
    output logic [CNT_WIDTH-1:0]              drop_cnt_o,
    output logic                              overflow_o
);

    logic [TS_WIDTH-1:0]  ts_q;
    logic [CNT_WIDTH-1:0] drop_cnt_q;
    logic                 overflow_q;
    logic                 w_dup;
    logic                 w_capture;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_drop;
    rm_report_rec_t       w_push_rec;
    rm_report_rec_t       w_head_rec;

`ifdef RM_REPORT_DEDUP_EN
    logic [NUM_REPORTS-1:0] prev_q;

    // Remember the bitmap of the last run cycle, zero vectors included
    always_ff @(posedge clk) begin
        if (reset)    prev_q <= '0;
        else if (run) prev_q <= report_i;
    end

    assign w_dup = (report_i == prev_q);
`else
    assign w_dup = 1'b0;
`endif

    assign w_capture         = run && (|report_i) && !w_dup;
    assign w_pop             = rec_valid_o && rec_ready_i;
    assign w_drop            = w_capture && w_full && !w_pop;
    assign w_push_rec.ts     = ts_q;
    assign w_push_rec.bitmap = report_i;

    rm_report_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_capture),
        .data_i  (w_push_rec),
        .pop_i   (w_pop),
        .data_o  (w_head_rec),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (fifo_level_o)
    );

    assign rec_valid_o  = !w_empty;
    assign rec_ts_o     = w_head_rec.ts;
    assign rec_bitmap_o = w_head_rec.bitmap;
    assign drop_cnt_o   = drop_cnt_q;
    assign overflow_o   = overflow_q;

    // Timestamp advances once per consumed symbol and wraps silently
    always_ff @(posedge clk) begin
        if (reset)    ts_q <= '0;
        else if (run) ts_q <= ts_q + TS_WIDTH'(1);
    end

    // Saturating drop counter and sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else if (w_drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rm_report_collector.sv
// ============================================================================
// Module      : tb_rm_report_collector
// Description : Directed self-checking bench for rm_report_collector.
//               Expectations for the dedup scenario follow RM_REPORT_DEDUP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rm_report_collector;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [3:0]  report_i = '0;
    logic        rec_valid_o;
    logic        rec_ready_i = 1'b0;
    logic [31:0] rec_ts_o;
    logic [3:0]  rec_bitmap_o;
    logic [3:0]  fifo_level_o;
    logic [15:0] drop_cnt_o;
    logic        overflow_o;

    int n_vec  = 0;
    int n_miss = 0;

    rm_report_collector dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .report_i     (report_i),
        .rec_valid_o  (rec_valid_o),
        .rec_ready_i  (rec_ready_i),
        .rec_ts_o     (rec_ts_o),
        .rec_bitmap_o (rec_bitmap_o),
        .fifo_level_o (fifo_level_o),
        .drop_cnt_o   (drop_cnt_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; report_i = '0; rec_ready_i = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    logic [31:0] exp_ts [4];
    logic [3:0]  exp_bm [4];
    int          exp_n;
    logic [3:0]  dd_vec [5];

    initial begin
        #1;
        do_reset();

        // Reset state
        check("rst_valid", rec_valid_o, 0);
        check("rst_level", fifo_level_o, 0);
        check("rst_drop", drop_cnt_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_ts", rec_ts_o, 0);
        check("rst_bitmap", rec_bitmap_o, 0);

        // Scenario 1: three empty run cycles then a single report
        run = 1'b1; report_i = 4'b0000;
        repeat (3) tick();
        check("s1_no_rec", rec_valid_o, 0);
        report_i = 4'b0100;
        tick();
        run = 1'b0; report_i = '0;
        check("s1_valid", rec_valid_o, 1);
        check("s1_ts", rec_ts_o, 3);
        check("s1_bitmap", rec_bitmap_o, 4'b0100);
        check("s1_level", fifo_level_o, 1);
        rec_ready_i = 1'b1;
        tick();
        rec_ready_i = 1'b0;
        check("s1_popped", rec_valid_o, 0);

        // Scenario 2: ten captures into an eight-deep buffer with no drain
        do_reset();
        run = 1'b1; report_i = 4'b0001;
        repeat (10) tick();
        check("s2_level", fifo_level_o, 8);
        check("s2_drop", drop_cnt_o, 2);
        check("s2_ovf", overflow_o, 1);
        check("s2_head_ts", rec_ts_o, 0);

        // Scenario 3: push and pop together while full (ts now 10)
        report_i = 4'b1000; rec_ready_i = 1'b1;
        tick();
        run = 1'b0; report_i = '0; rec_ready_i = 1'b0;
        check("s3_level", fifo_level_o, 8);
        check("s3_drop", drop_cnt_o, 2);
        check("s3_head_ts", rec_ts_o, 1);

        // Scenario 4: head held stable under backpressure
        for (int i = 0; i < 5; i++) begin
            tick();
            check("s4_hold_ts", rec_ts_o, 1);
            check("s4_hold_bm", rec_bitmap_o, 4'b0001);
        end
        rec_ready_i = 1'b1;
        tick();
        rec_ready_i = 1'b0;
        check("s4_next_ts", rec_ts_o, 2);
        check("s4_level", fifo_level_o, 7);

        // Drain the remainder in order, ending with the tail record from scenario 3
        rec_ready_i = 1'b1;
        for (int t = 2; t <= 7; t++) begin
            check("drain_ts", rec_ts_o, 64'(t));
            check("drain_bm", rec_bitmap_o, 4'b0001);
            tick();
        end
        check("drain_tail_ts", rec_ts_o, 10);
        check("drain_tail_bm", rec_bitmap_o, 4'b1000);
        tick();
        rec_ready_i = 1'b0;
        check("drain_empty", rec_valid_o, 0);
        check("drain_level", fifo_level_o, 0);

        // Scenario 5: repeated, zero and changed bitmaps
        do_reset();
        dd_vec[0] = 4'b0011; dd_vec[1] = 4'b0011; dd_vec[2] = 4'b0000;
        dd_vec[3] = 4'b0011; dd_vec[4] = 4'b0101;
`ifdef RM_REPORT_DEDUP_EN
        exp_n = 3;
        exp_ts[0] = 0; exp_bm[0] = 4'b0011;
        exp_ts[1] = 3; exp_bm[1] = 4'b0011;
        exp_ts[2] = 4; exp_bm[2] = 4'b0101;
        exp_ts[3] = 0; exp_bm[3] = 4'b0000;
`else
        exp_n = 4;
        exp_ts[0] = 0; exp_bm[0] = 4'b0011;
        exp_ts[1] = 1; exp_bm[1] = 4'b0011;
        exp_ts[2] = 3; exp_bm[2] = 4'b0011;
        exp_ts[3] = 4; exp_bm[3] = 4'b0101;
`endif
        run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            report_i = dd_vec[i];
            tick();
        end
        run = 1'b0; report_i = '0;
        check("s5_level", fifo_level_o, 64'(exp_n));
        check("s5_drop", drop_cnt_o, 0);
        rec_ready_i = 1'b1;
        for (int i = 0; i < exp_n; i++) begin
            check("s5_ts", rec_ts_o, exp_ts[i]);
            check("s5_bm", rec_bitmap_o, exp_bm[i]);
            tick();
        end
        rec_ready_i = 1'b0;
        check("s5_empty", rec_valid_o, 0);

        // Scenario 6: reset with five records buffered and overflow set
        do_reset();
        run = 1'b1; report_i = 4'b0010;
        repeat (9) tick();
        run = 1'b0; report_i = '0; rec_ready_i = 1'b1;
        repeat (3) tick();
        rec_ready_i = 1'b0;
        check("s6_pre_level", fifo_level_o, 5);
        check("s6_pre_ovf", overflow_o, 1);
        check("s6_pre_drop", drop_cnt_o, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("s6_level", fifo_level_o, 0);
        check("s6_valid", rec_valid_o, 0);
        check("s6_drop", drop_cnt_o, 0);
        check("s6_ovf", overflow_o, 0);
        run = 1'b1; report_i = 4'b0001;
        tick();
        run = 1'b0; report_i = '0;
        check("s6_first_ts", rec_ts_o, 0);
        check("s6_first_valid", rec_valid_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
